instr_packer: RTL and testbench

- Inverse of the core's immediate generator: accepts decoded instruction fields plus an immediate and packs them into a 32-bit RV32I instruction word.
- Range-checks the immediate against the decoder's conventions, so that decoding the packed word returns exactly the supplied immediate.
- Writes each legal word into instruction memory at an auto-incrementing word address, with an ack handshake and timeout.
- Used by the boot/program-load path and by self-test benches.

---
 rtl/instr_packer.sv | 197 +++++++++++++++++++
 tb/tb_instr_packer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_packer.sv
// instr_packer: packs decoded RV32I fields plus an immediate into a 32-bit
// instruction word. It rejects immediates that the core's immediate generator
// could not reproduce, then writes each legal word to instruction memory at an
// auto-incrementing word address. The write uses an ack handshake with a timeout.
module instr_packer #(
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   instr_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]     T_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]     T_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_MAX   = '1;

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHIFT = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'd3;

  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_FORMAT  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, PACK, WRITE} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;

  // Captured field bundle, stable through PACK
  logic [2:0]  f_fmt;
  logic [6:0]  f_opcode;
  logic [4:0]  f_rd;
  logic [4:0]  f_rs1;
  logic [4:0]  f_rs2;
  logic [2:0]  f_funct3;
  logic [6:0]  f_funct7;
  logic [31:0] f_imm;

  logic [31:0] word;
  logic        imm_ok;
  logic        fmt_bad;
  logic        s12_ok;
  logic        s20_ok;

  assign in_ready = (state == IDLE);

  // Sign-range tests shared by several formats: bits above the field must all
  // equal the field's sign bit.
  assign s12_ok = (&f_imm[31:11]) | ~(|f_imm[31:11]);
  assign s20_ok = (&f_imm[31:19]) | ~(|f_imm[31:19]);

  // Pack the captured bundle into an instruction word and judge the immediate
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave a latch.
    word    = '0;
    imm_ok  = 1'b0;
    fmt_bad = 1'b0;
    case (f_fmt)
      FMT_R: begin
        word   = {f_funct7, f_rs2, f_rs1, f_funct3, f_rd, f_opcode};
        imm_ok = 1'b1;
      end
      FMT_I: begin
        word = {f_imm[11:0], f_rs1, f_funct3, f_rd, f_opcode};
        // Loads are zero-extended by the decoder, so only 0..4095 round-trips.
        imm_ok = (f_opcode == OP_LOAD) ? ~(|f_imm[31:12]) : s12_ok;
      end
      FMT_SHIFT: begin
        word   = {f_funct7, f_imm[4:0], f_rs1, f_funct3, f_rd, f_opcode};
        imm_ok = ~(|f_imm[31:5]);
      end
      FMT_S: begin
        word   = {f_imm[11:5], f_rs2, f_rs1, f_funct3, f_imm[4:0], f_opcode};
        imm_ok = s12_ok;
      end
      FMT_B: begin
        word   = {f_imm[11], f_imm[9:4], f_rs2, f_rs1, f_funct3,
                  f_imm[3:0], f_imm[10], f_opcode};
        imm_ok = s12_ok;
      end
      FMT_U: begin
        word   = {f_imm[19:0], f_rd, f_opcode};
        imm_ok = s20_ok;
      end
      FMT_J: begin
        word   = {f_imm[19], f_imm[9:0], f_imm[10], f_imm[18:11], f_rd, f_opcode};
        imm_ok = s20_ok;
      end
      default: fmt_bad = 1'b1;
    endcase
  end

  // Control FSM: accept, pack, write with ack/timeout; all outputs registered
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err_valid   <= 1'b0;
      err_code    <= 2'd0;
      instr_count <= '0;
      f_fmt       <= '0;
      f_opcode    <= '0;
      f_rd        <= '0;
      f_rs1       <= '0;
      f_rs2       <= '0;
      f_funct3    <= '0;
      f_funct7    <= '0;
      f_imm       <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The base takes effect now, so a bundle accepted this cycle uses it.
          if (base_load) mem_addr <= base_addr;
          if (in_valid) begin
            f_fmt    <= fmt;
            f_opcode <= opcode;
            f_rd     <= rd;
            f_rs1    <= rs1;
            f_rs2    <= rs2;
            f_funct3 <= funct3;
            f_funct7 <= funct7;
            f_imm    <= imm;
            state    <= PACK;
          end
        end
        PACK: begin
          if (fmt_bad) begin
            err_code  <= ERR_FORMAT;
            err_valid <= 1'b1;
            state     <= IDLE;
          end else if (!imm_ok) begin
            err_code  <= ERR_RANGE;
            err_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            mem_wdata <= word;
            mem_we    <= 1'b1;
            tcnt      <= '0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          // An ack in the final allowed cycle still counts as a success.
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= mem_addr + A_ONE;
            if (instr_count != C_MAX) instr_count <= instr_count + C_ONE;
            state    <= IDLE;
          end else if (tcnt == T_LAST) begin
            mem_we    <= 1'b0;
            err_code  <= ERR_TIMEOUT;
            err_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: directed cases plus randomized bundles.
// Expected results come from a behavioural model that checks immediate legality
// with signed arithmetic and decodes the written word with the standard RV32I
// immediate rules.
module tb_instr_packer;

  localparam int ADDR_W      = 8;
  localparam int ACK_TIMEOUT = 15;
  localparam int CNT_MAX     = (1 << (ADDR_W + 1)) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   instr_count;

  instr_packer #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .base_load(base_load), .base_addr(base_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .err_valid(err_valid), .err_code(err_code), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int          exp_addr  = 0;
  int          exp_count = 0;
  int          exp_code  = 0;
  logic [31:0] last_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Legality: does the immediate lie in the range the decoder can produce?
  function automatic bit model_legal(input logic [2:0] f, input logic [6:0] op,
                                     input logic [31:0] im);
    int s;
    s = $signed(im);
    case (f)
      3'd0:       return 1'b1;
      3'd1:       return (op == 7'd3) ? (im < 32'd4096) : (s >= -2048 && s <= 2047);
      3'd2, 3'd3: return (s >= -2048 && s <= 2047);
      3'd4, 3'd5: return (s >= -524288 && s <= 524287);
      3'd6:       return (im < 32'd32);
      default:    return 1'b0;
    endcase
  endfunction

  // Immediate generator: standard RV32I decoding, with B/J reported as halfword
  // offsets and U as the raw 20-bit field.
  function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [6:0] op,
                                             input logic [31:0] w);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [19:0] u20;
    logic signed [20:0] j21;
    int v;
    v = 0;
    case (f)
      3'd1: begin
        i12 = w[31:20];
        v = (op == 7'd3) ? int'(w[31:20]) : int'(i12);
      end
      3'd6: v = int'(w[24:20]);
      3'd2: begin i12 = {w[31:25], w[11:7]}; v = i12; end
      3'd3: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = b13; v = v >>> 1; end
      3'd4: begin u20 = w[31:12]; v = u20; end
      3'd5: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = j21; v = v >>> 1; end
      default: v = 0;
    endcase
    return v;
  endfunction

  // Non-immediate fields that a format carries, gathered in one vector
  function automatic logic [31:0] field_sig(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7);
    bit has_rd, has_s1, has_s2, has_f3, has_f7;
    has_rd = (f == 3'd0 || f == 3'd1 || f == 3'd6 || f == 3'd4 || f == 3'd5);
    has_s1 = (f <= 3'd3 || f == 3'd6);
    has_s2 = (f == 3'd0 || f == 3'd2 || f == 3'd3);
    has_f3 = has_s1;
    has_f7 = (f == 3'd0 || f == 3'd6);
    return {op, has_rd ? d : 5'd0, has_s1 ? s1 : 5'd0, has_s2 ? s2 : 5'd0,
            has_f3 ? f3 : 3'd0, has_f7 ? f7 : 7'd0};
  endfunction

  // One bundle from IDLE to back in IDLE; ack_delay >= ACK_TIMEOUT means never ack.
  task automatic run_bundle(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im, input bit do_base, input logic [7:0] base,
      input int ack_delay, input bit noise);
    int waited;
    bit acked;
    logic [31:0] w;
    check("idle_ready", in_ready, 1);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1; base_load = do_base; base_addr = base;
    if (do_base) exp_addr = base;
    @(posedge clk); #1;
    // Base loads and acks during PACK must have no effect
    in_valid = 0; base_load = noise; base_addr = 8'($urandom); mem_ack = noise;
    check("pack_ready", in_ready, 0);
    check("pack_we", mem_we, 0);
    @(posedge clk); #1;
    base_load = 0; mem_ack = 0;
    if (!model_legal(f, op, im)) begin
      exp_code = (f == 3'd7) ? 2 : 1;
      check("err_valid", err_valid, 1);
      check("err_code", err_code, exp_code);
      check("err_we", mem_we, 0);
      check("err_addr", mem_addr, exp_addr);
      check("err_count", instr_count, exp_count);
      check("err_ready", in_ready, 1);
      @(posedge clk); #1;
      check("err_pulse_end", err_valid, 0);
      return;
    end
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, exp_addr);
    check("wr_errv", err_valid, 0);
    w = mem_wdata;
    last_word = w;
    check("rt_fields", field_sig(f, w[6:0], w[11:7], w[19:15], w[24:20], w[14:12], w[31:25]),
          field_sig(f, op, d, s1, s2, f3, f7));
    if (f != 3'd0) check("rt_imm", decode_imm(f, op, w), im);
    waited = 0;
    acked = 0;
    while (!acked && waited < ACK_TIMEOUT) begin
      check("wr_hold_we", mem_we, 1);
      check("wr_hold_data", mem_wdata, w);
      if (waited == ack_delay) mem_ack = 1;
      @(posedge clk); #1;
      if (mem_ack) acked = 1;
      mem_ack = 0;
      waited++;
    end
    if (acked) begin
      exp_addr = (exp_addr + 1) % (1 << ADDR_W);
      if (exp_count < CNT_MAX) exp_count++;
      check("ack_we", mem_we, 0);
      check("ack_addr", mem_addr, exp_addr);
      check("ack_count", instr_count, exp_count);
      check("ack_ready", in_ready, 1);
      check("ack_errv", err_valid, 0);
      check("ack_code", err_code, exp_code);
    end else begin
      exp_code = 3;
      check("to_we", mem_we, 0);
      check("to_errv", err_valid, 1);
      check("to_code", err_code, exp_code);
      check("to_addr", mem_addr, exp_addr);
      check("to_count", instr_count, exp_count);
      check("to_ready", in_ready, 1);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [31:0] t;
    logic [31:0] r_imm;
    logic [2:0]  r_fmt;
    logic [6:0]  r_op;
    int          r_delay;

    rst_n = 0; in_valid = 0; base_load = 0; base_addr = '0; mem_ack = 0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    #12;
    check("rst_ready", in_ready, 1);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_errv", err_valid, 0);
    check("rst_code", err_code, 0);
    check("rst_count", instr_count, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // ADDI x5, x0, -1
    run_bundle(3'd1, 7'd19, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    check("addi_word", last_word, 32'hFFF0_0293);
    check("addi_count", instr_count, 1);

    // B-type immediate out of range
    run_bundle(3'd3, 7'd99, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0FFF, 0, 0, 0, 0);

    // Load: 0x800 is legal (zero-extended), 0xFFFFF800 is not
    run_bundle(3'd1, 7'd3, 5'd7, 5'd2, 5'd0, 3'd2, 7'd0, 32'h0000_0800, 0, 0, 1, 0);
    check("load_field", last_word[31:20], 32'h800);
    run_bundle(3'd1, 7'd3, 5'd7, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFF_F800, 0, 0, 0, 0);

    // Illegal format
    run_bundle(3'd7, 7'd51, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, 0, 0, 0, 0);

    // Address wrap after a standalone base load
    base_load = 1; base_addr = 8'hFF;
    @(posedge clk); #1;
    base_load = 0;
    exp_addr = 8'hFF;
    check("base_addr", mem_addr, 8'hFF);
    run_bundle(3'd0, 7'd51, 5'd1, 5'd2, 5'd3, 3'd0, 7'd32, 32'h0, 0, 0, 0, 0);
    check("wrap_addr", mem_addr, 0);
    run_bundle(3'd4, 7'd55, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF8_0000, 0, 0, 0, 0);
    check("wrap_next", mem_addr, 1);

    // Timeout, then the next bundle reuses the address; then ack on the last cycle
    run_bundle(3'd5, 7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0007_FFFF, 0, 0, ACK_TIMEOUT, 0);
    run_bundle(3'd2, 7'd35, 5'd0, 5'd4, 5'd6, 3'd2, 7'd0, 32'hFFFF_F800, 0, 0, 0, 0);
    run_bundle(3'd6, 7'd19, 5'd3, 5'd4, 5'd0, 3'd1, 7'd0, 32'd31, 0, 0, ACK_TIMEOUT - 1, 0);
    run_bundle(3'd1, 7'd19, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 0, 0, 0, 0);

    // Leave a timeout code standing, then reset in the middle of a write
    run_bundle(3'd0, 7'd51, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0, 0, 0, ACK_TIMEOUT, 0);
    fmt = 3'd0; opcode = 7'd51; rd = 5'd2; rs1 = 5'd3; rs2 = 5'd4; funct3 = 3'd0; funct7 = 7'd0;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    check("rst_mid_pre_we", mem_we, 1);
    #2 rst_n = 0;
    #1;
    check("rst_mid_we", mem_we, 0);
    check("rst_mid_addr", mem_addr, 0);
    check("rst_mid_wdata", mem_wdata, 0);
    check("rst_mid_code", err_code, 0);
    check("rst_mid_count", instr_count, 0);
    check("rst_mid_ready", in_ready, 1);
    exp_addr = 0; exp_count = 0; exp_code = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Randomized round-trip against the immediate generator
    for (int i = 0; i < 120; i++) begin
      r_fmt = 3'($urandom_range(0, 7));
      r_op  = ($urandom_range(0, 3) == 0) ? 7'd3 : 7'($urandom);
      case ($urandom_range(0, 2))
        0: r_imm = $urandom;
        1: begin t = $urandom; r_imm = t >>> $urandom_range(11, 31); end
        default: r_imm = $urandom_range(0, 40);
      endcase
      r_delay = ($urandom_range(0, 9) == 0) ? ACK_TIMEOUT : $urandom_range(0, 3);
      run_bundle(r_fmt, r_op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                 7'($urandom), r_imm, ($urandom_range(0, 3) == 0), 8'($urandom),
                 r_delay, $urandom_range(0, 1));
    end

    // Drive the write counter into saturation
    while (exp_count < CNT_MAX + 3) begin
      run_bundle(3'd0, 7'd51, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, 0, 0, 0, 0);
      if (exp_count == CNT_MAX) begin
        run_bundle(3'd0, 7'd51, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, 0, 0, 0, 0);
        check("sat_count", instr_count, CNT_MAX);
        break;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
